// File: rtl/alu_md.sv
// ALU plus iterative multiply/divide unit with hi/lo result registers.
// Define MD_DIV_EN to build the restoring divider; without it DIVU/DIV starts complete at once with hi/lo untouched.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  md_state_t state, state_n;

  logic [WIDTH-1:0] bout, s;
  logic             ovf_raw;

  logic [WIDTH-1:0]   ph, pl, mc;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               last;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_t;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

`ifdef MD_DIV_EN
  logic             is_div, neg_r, bzero;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH:0]   div_sh, div_df;
  logic             div_ok;
  logic [WIDTH-1:0] div_r, div_q;
`endif

  always_comb begin
    bout    = f[2] ? ~b : b;
    s       = a + bout + {{(WIDTH-1){1'b0}}, f[2]};
    ovf_raw = (a[MSB] == bout[MSB]) && (s[MSB] != a[MSB]);
    y       = '0;
    case (f[1:0])
      2'b00:   y = a & bout;
      2'b01:   y = a | bout;
      2'b10:   y = s;
      default: y = {{(WIDTH-1){1'b0}}, (f[2] ? (s[MSB] ^ ovf_raw) : (a < b))};
    endcase
    overflow = (f[1:0] == 2'b10) && ovf_raw;
    zero     = (y == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Without the divider a divide request skips RUN entirely.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (md_start) begin
`ifdef MD_DIV_EN
          state_n = RUN;
`else
          state_n = md_op[1] ? DONE : RUN;
`endif
        end
      end
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sa    = md_op[0] & a[MSB];
    sb    = md_op[0] & b[MSB];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    mul_t    = {1'b0, ph} + (pl[0] ? {1'b0, mc} : '0);
    mul_hi   = mul_t[WIDTH:1];
    mul_lo   = {mul_t[0], pl[MSB:1]};
    prod     = {mul_hi, mul_lo};
    prod_fix = neg_q ? -prod : prod;

    step_hi = mul_hi;
    step_lo = mul_lo;
    fin_hi  = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo  = prod_fix[WIDTH-1:0];

`ifdef MD_DIV_EN
    div_sh = {ph, pl[MSB]};
    div_df = div_sh - {1'b0, mc};
    div_ok = ~div_df[WIDTH];
    div_r  = div_ok ? div_df[MSB:0] : div_sh[MSB:0];
    div_q  = {pl[MSB-1:0], div_ok};
    if (is_div) begin
      step_hi = div_r;
      step_lo = div_q;
      // A zero divisor leaves an all-ones quotient; report the raw dividend as remainder.
      if (bzero) begin
        fin_hi = a_cap;
        fin_lo = '1;
      end else begin
        fin_hi = neg_r ? -div_r : div_r;
        fin_lo = neg_q ? -div_q : div_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph    <= '0;
      pl    <= '0;
      mc    <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MD_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
      a_cap  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            ph    <= '0;
            pl    <= mag_a;
            mc    <= mag_b;
            cnt   <= '0;
            neg_q <= sa ^ sb;
`ifdef MD_DIV_EN
            is_div <= md_op[1];
            neg_r  <= sa;
            bzero  <= (b == '0);
            a_cap  <= a;
`endif
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        RUN: begin
          ph  <= step_hi;
          pl  <= step_lo;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
// Divide vectors run only when MD_DIV_EN is defined; otherwise the bypass behaviour is checked.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  f = '0;
  logic [31:0] y;
  logic        zero, overflow;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int lat;
  int pulses;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f), .y(y), .zero(zero),
    .overflow(overflow), .md_start(md_start), .md_op(md_op), .hi_we(hi_we),
    .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fv, input logic [31:0] av, input logic [31:0] bv);
    f = fv;
    a = av;
    b = bv;
    #1;
  endtask

  // Leaves the bench at the first falling edge after the start edge.
  task automatic startMd(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    md_op = op;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic writeReg(input bit toHi, input logic [31:0] v);
    @(negedge clk);
    a = v;
    hi_we = toHi;
    lo_we = !toHi;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;

    applyStimulus(3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    checkOutput("and", y, 32'h00F0_000F);
    applyStimulus(3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    checkOutput("or", y, 32'hFFF0_0FFF);
    applyStimulus(3'b100, 32'hFFFF_0000, 32'h00FF_00FF);
    checkOutput("andn", y, 32'hFF00_0000);
    applyStimulus(3'b101, 32'h0000_0000, 32'hFFFF_FFF0);
    checkOutput("orn", y, 32'h0000_000F);
    applyStimulus(3'b110, 32'd5, 32'd5);
    checkOutput("sub_y", y, 0);
    checkOutput("sub_zero", zero, 1);
    checkOutput("sub_ovf", overflow, 0);
    applyStimulus(3'b110, 32'h8000_0000, 32'd1);
    checkOutput("subov_y", y, 32'h7FFF_FFFF);
    checkOutput("subov_ovf", overflow, 1);
    applyStimulus(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    checkOutput("slt_y", y, 0);
    checkOutput("slt_ovf", overflow, 0);
    checkOutput("slt_zero", zero, 1);
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt_neg", y, 1);
    applyStimulus(3'b011, 32'h7FFF_FFFF, 32'h8000_0000);
    checkOutput("sltu_y", y, 1);
    applyStimulus(3'b010, 32'h7FFF_FFFF, 32'd1);
    checkOutput("add_y", y, 32'h8000_0000);
    checkOutput("add_ovf", overflow, 1);
    checkOutput("add_zero", zero, 0);

    startMd(2'b00, 32'hFFFF_FFFF, 32'd2);
    waitDone(lat);
    checkOutput("multu_lat", lat, 33);
    checkOutput("multu_hi", hi, 32'h0000_0001);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFE);
    @(negedge clk);
    checkOutput("multu_idle", {busy, done}, 0);

    startMd(2'b01, 32'hFFFF_FFFD, 32'd5);
    waitDone(lat);
    checkOutput("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    startMd(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    waitDone(lat);
    checkOutput("mult_pos", {hi, lo}, 64'd6);

    // Second start and an MTLO during RUN must both be dropped.
    startMd(2'b00, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    md_start = 1'b1;
    lo_we = 1'b1;
    md_op = 2'b01;
    a = 32'h0000_1234;
    @(negedge clk);
    md_start = 1'b0;
    lo_we = 1'b0;
    pulses = 0;
    repeat (60) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("busy_pulses", pulses, 1);
    checkOutput("busy_lo", lo, 32'd63);
    checkOutput("busy_hi", hi, 0);
    checkOutput("busy_after", busy, 0);

    startMd(2'b01, 32'hFFFF_FFFB, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_hilo", {hi, lo}, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_nodone", pulses, 0);
    startMd(2'b00, 32'd3, 32'd4);
    waitDone(lat);
    checkOutput("post_rst_mul", {hi, lo}, 64'd12);

    writeReg(1'b1, 32'h0000_CAFE);
    checkOutput("mthi", hi, 32'h0000_CAFE);
    writeReg(1'b0, 32'h0000_BEEF);
    checkOutput("mtlo", lo, 32'h0000_BEEF);

`ifdef MD_DIV_EN
    startMd(2'b11, 32'hFFFF_FFF9, 32'd2);
    waitDone(lat);
    checkOutput("div_lat", lat, 33);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    startMd(2'b11, 32'd7, 32'hFFFF_FFFE);
    waitDone(lat);
    checkOutput("div_negb", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
    startMd(2'b10, 32'd5, 32'd0);
    waitDone(lat);
    checkOutput("divu_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    startMd(2'b10, 32'd100, 32'd7);
    waitDone(lat);
    checkOutput("divu", {hi, lo}, {32'd2, 32'd14});
    startMd(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(lat);
    checkOutput("div_minneg", {hi, lo}, {32'd0, 32'h8000_0000});
`else
    startMd(2'b10, 32'd100, 32'd7);
    checkOutput("nodiv_busy", busy, 1);
    waitDone(lat);
    checkOutput("nodiv_lat", lat, 1);
    @(negedge clk);
    checkOutput("nodiv_idle", busy, 0);
    checkOutput("nodiv_hilo", {hi, lo}, {32'h0000_CAFE, 32'h0000_BEEF});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
